// File: rtl/ts_fifo_reader.sv
// Read-side consumer of the async TS FIFO: drains {data, valid, sync} words,
// recovers packet alignment on the sync byte and emits a framed byte stream.
module ts_fifo_reader #(
  parameter int unsigned PKT_LEN   = 188,
  parameter logic [7:0]  SYNC_BYTE = 8'h47,
  parameter int unsigned LOCK_PKTS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [9:0]  fifo_data,
  input  logic        fifo_empty,
  output logic        r_en,
  output logic [7:0]  ts_data,
  output logic        ts_valid,
  output logic        ts_sop,
  output logic        ts_eop,
  output logic        locked,
  output logic [31:0] pkt_count,
  output logic [31:0] err_count
);

  typedef enum logic [1:0] {HUNT, PAYLOAD, EXPECT} state_e;

  localparam int unsigned GOOD_W   = $clog2(LOCK_PKTS + 1);
  localparam logic [7:0]  LAST_IDX = 8'(PKT_LEN - 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_PKTS);

  state_e            state_q, state_d;
  logic [7:0]        byte_cnt_q, byte_cnt_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic              rd_vld_q;
  logic              locked_q, locked_d;
  logic [31:0]       pkt_count_q, pkt_count_d;
  logic [31:0]       err_count_q, err_count_d;
  logic [7:0]        ts_data_q, ts_data_d;
  logic              ts_valid_q, ts_valid_d;
  logic              ts_sop_q, ts_sop_d;
  logic              ts_eop_q, ts_eop_d;

  logic [7:0] w_data;
  logic       w_sync;
  logic       accepted;
  logic       sync_word;
  logic       start_pkt;
  logic       frame_err;

  // Reset gates the read so a word is never popped while state is being cleared.
  assign r_en      = en & ~fifo_empty & ~rst;
  assign w_data    = fifo_data[9:2];
  assign w_sync    = fifo_data[0];
  assign accepted  = rd_vld_q & fifo_data[1];
  assign sync_word = accepted & w_sync & (w_data == SYNC_BYTE);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    good_cnt_d  = good_cnt_q;
    locked_d    = locked_q;
    pkt_count_d = pkt_count_q;
    err_count_d = err_count_q;
    ts_data_d   = ts_data_q;
    ts_valid_d  = 1'b0;
    ts_sop_d    = 1'b0;
    ts_eop_d    = 1'b0;
    start_pkt   = 1'b0;
    frame_err   = 1'b0;

    if (accepted) begin
      case (state_q)
        HUNT: start_pkt = sync_word;
        PAYLOAD: begin
          if (!w_sync) begin
            byte_cnt_d = byte_cnt_q + 8'd1;
            ts_valid_d = 1'b1;
            ts_data_d  = w_data;
            if (byte_cnt_q == LAST_IDX) begin
              ts_eop_d = 1'b1;
              state_d  = EXPECT;
              if (pkt_count_q != '1) pkt_count_d = pkt_count_q + 32'd1;
              if (good_cnt_q != GOOD_MAX) good_cnt_d = good_cnt_q + 1'b1;
              if (good_cnt_d == GOOD_MAX) locked_d = 1'b1;
            end
          end else begin
            // A sync-flagged word inside a packet means the previous packet was short.
            frame_err = 1'b1;
            if (sync_word) start_pkt = 1'b1;
            else           state_d   = HUNT;
          end
        end
        EXPECT: begin
          if (sync_word) start_pkt = 1'b1;
          else begin
            frame_err = 1'b1;
            state_d   = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (start_pkt) begin
      state_d    = PAYLOAD;
      byte_cnt_d = 8'd1;
      ts_valid_d = 1'b1;
      ts_sop_d   = 1'b1;
      ts_data_d  = w_data;
    end

    if (frame_err) begin
      if (err_count_q != '1) err_count_d = err_count_q + 32'd1;
      good_cnt_d = '0;
      locked_d   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      byte_cnt_q  <= '0;
      good_cnt_q  <= '0;
      rd_vld_q    <= 1'b0;
      locked_q    <= 1'b0;
      pkt_count_q <= '0;
      err_count_q <= '0;
      ts_data_q   <= '0;
      ts_valid_q  <= 1'b0;
      ts_sop_q    <= 1'b0;
      ts_eop_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      good_cnt_q  <= good_cnt_d;
      rd_vld_q    <= r_en;
      locked_q    <= locked_d;
      pkt_count_q <= pkt_count_d;
      err_count_q <= err_count_d;
      ts_data_q   <= ts_data_d;
      ts_valid_q  <= ts_valid_d;
      ts_sop_q    <= ts_sop_d;
      ts_eop_q    <= ts_eop_d;
    end
  end

  assign ts_data   = ts_data_q;
  assign ts_valid  = ts_valid_q;
  assign ts_sop    = ts_sop_q;
  assign ts_eop    = ts_eop_q;
  assign locked    = locked_q;
  assign pkt_count = pkt_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_ts_fifo_reader.sv
// Randomized bench for ts_fifo_reader: a queue-backed FIFO model feeds words and a
// packet-level reference model predicts the framed output stream and counters.
module tb_ts_fifo_reader;

  localparam int PKT_LEN   = 188;
  localparam int LOCK_PKTS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [9:0]  fifo_data = '0;
  logic        fifo_empty = 1'b1;
  logic        r_en;
  logic [7:0]  ts_data;
  logic        ts_valid, ts_sop, ts_eop, locked;
  logic [31:0] pkt_count, err_count;

  ts_fifo_reader #(.PKT_LEN(PKT_LEN), .SYNC_BYTE(8'h47), .LOCK_PKTS(LOCK_PKTS)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .r_en(r_en), .ts_data(ts_data), .ts_valid(ts_valid), .ts_sop(ts_sop),
    .ts_eop(ts_eop), .locked(locked), .pkt_count(pkt_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int ren_bad = 0;
  bit stall_rand = 0;
  bit en_rand = 0;

  logic [9:0]  fq[$];     // words waiting in the FIFO
  logic [11:0] exp_q[$];  // {valid, locked, sop, eop, data}
  logic [11:0] act_q[$];

  // Reference model state: position in current packet (0 = none) and whether a sync must follow.
  int m_pos, m_good, m_err, m_pkt;
  bit m_expect, m_lock;

  always @(negedge clk)
    if (rst === 1'b0 && (ts_valid || ts_sop || ts_eop))
      act_q.push_back({ts_valid, locked, ts_sop, ts_eop, ts_data});

  function automatic void model_clear();
    m_pos = 0; m_good = 0; m_err = 0; m_pkt = 0; m_expect = 0; m_lock = 0;
  endfunction

  function automatic void model_start(logic [7:0] d);
    m_pos = 1;
    m_expect = 0;
    exp_q.push_back({1'b1, m_lock, 1'b1, 1'b0, d});
  endfunction

  function automatic void model_error();
    m_err++;
    m_good = 0;
    m_lock = 0;
  endfunction

  function automatic void push_word(logic [7:0] d, logic v, logic s);
    bit is_sw;
    fq.push_back({d, v, s});
    if (!v) return;
    is_sw = s && (d == 8'h47);
    if (m_pos == 0) begin
      if (is_sw) model_start(d);
      else if (m_expect) begin
        model_error();
        m_expect = 0;
      end
    end else if (!s) begin
      m_pos++;
      if (m_pos == PKT_LEN) begin
        m_pkt++;
        if (m_good < LOCK_PKTS) m_good++;
        if (m_good == LOCK_PKTS) m_lock = 1;
        exp_q.push_back({1'b1, m_lock, 1'b0, 1'b1, d});
        m_pos = 0;
        m_expect = 1;
      end else begin
        exp_q.push_back({1'b1, m_lock, 1'b0, 1'b0, d});
      end
    end else begin
      model_error();
      if (is_sw) model_start(d);
      else m_pos = 0;
    end
  endfunction

  // Sync word followed by n-1 payload bytes; optional valid=0 bubbles carrying junk.
  function automatic void push_packet(int n, bit bubbles);
    push_word(8'h47, 1'b1, 1'b1);
    for (int i = 1; i < n; i++) begin
      if (bubbles && $urandom_range(0, 4) == 0)
        push_word(($urandom_range(0, 1) == 0) ? 8'h47 : 8'($urandom), 1'b0, 1'($urandom));
      push_word(8'($urandom), 1'b1, 1'b0);
    end
  endfunction

  function automatic int first_diff();
    int n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (act_q[i] !== exp_q[i]) return i;
    if (act_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic step();
    logic pop;
    @(negedge clk);
    en = en_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
    fifo_empty = (fq.size() == 0) || (stall_rand && $urandom_range(0, 3) == 0);
    #1;
    if (r_en !== (en & ~fifo_empty)) ren_bad++;
    pop = r_en;
    @(posedge clk);
    #1;
    if (pop === 1'b1 && fq.size() > 0) fifo_data = fq.pop_front();
    else fifo_data = 10'($urandom);
  endtask

  task automatic drain(output bit timed_out);
    int budget = 20000;
    while (fq.size() > 0 && budget > 0) begin
      step();
      budget--;
    end
    repeat (4) step();
    timed_out = (fq.size() > 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fifo_empty = 1'b1;
    fq.delete();
    model_clear();
    repeat (2) @(negedge clk);
    act_q.delete();
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1; fifo_empty = 1'b0; rst = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({ts_data, ts_valid, ts_sop, ts_eop, locked} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_ts: got data=%h v=%b sop=%b eop=%b lock=%b, want all 0",
               ts_data, ts_valid, ts_sop, ts_eop, locked);
    end
    tests_run++;
    if (pkt_count !== 32'd0 || err_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_counts: got pkt=%0d err=%0d, want 0 0", pkt_count, err_count);
    end
    tests_run++;
    if (r_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ren: got %b, want 0 while rst high", r_en);
    end
    @(negedge clk);
    rst = 1'b0; fifo_empty = 1'b1;
    #1;
    tests_run++;
    if (r_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL ren_empty: got %b, want 0", r_en);
    end
    fifo_empty = 1'b0;
    #1;
    tests_run++;
    if (r_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL ren_ready: got %b, want 1", r_en);
    end
    fifo_empty = 1'b1;
    do_reset();
  endtask

  task automatic test_back_to_back();
    bit to;
    int idx;
    repeat (3) push_packet(PKT_LEN, 0);
    drain(to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL b2b_drain: %0d words left, want 0", fq.size()); end
    idx = first_diff();
    tests_run++;
    if (idx != -1) begin
      tests_failed++;
      $display("FAIL b2b_stream: idx=%0d act=%h exp=%h (act_n=%0d exp_n=%0d)", idx,
               (idx < act_q.size()) ? act_q[idx] : 12'hfff, (idx < exp_q.size()) ? exp_q[idx] : 12'hfff,
               act_q.size(), exp_q.size());
    end
    tests_run++;
    if (pkt_count !== 32'd3 || err_count !== 32'd0 || locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_status: got pkt=%0d err=%0d lock=%b, want 3 0 1", pkt_count, err_count, locked);
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_garbage();
    bit to;
    int idx;
    do_reset();
    repeat (5) push_word(8'hAA, 1'b1, 1'b0);
    push_packet(PKT_LEN, 0);
    drain(to);
    idx = first_diff();
    tests_run++;
    if (to || idx != -1) begin
      tests_failed++;
      $display("FAIL garbage_stream: idx=%0d timeout=%b act_n=%0d exp_n=%0d", idx, to, act_q.size(), exp_q.size());
    end
    tests_run++;
    if (act_q.size() == 0 || act_q[0] !== {4'b1010, 8'h47}) begin
      tests_failed++;
      $display("FAIL garbage_first: got %h, want sop with 0x47", (act_q.size() > 0) ? act_q[0] : 12'h000);
    end
    tests_run++;
    if (err_count !== 32'd0 || pkt_count !== 32'd1) begin
      tests_failed++;
      $display("FAIL garbage_counts: got err=%0d pkt=%0d, want 0 1", err_count, pkt_count);
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_short_packet();
    bit to;
    int idx;
    int err0, pkt0;
    err0 = m_err; pkt0 = m_pkt;
    push_packet(100, 0);
    push_packet(PKT_LEN, 0);
    push_packet(PKT_LEN, 0);
    drain(to);
    idx = first_diff();
    tests_run++;
    if (to || idx != -1) begin
      tests_failed++;
      $display("FAIL short_stream: idx=%0d timeout=%b act=%h exp=%h", idx, to,
               (idx >= 0 && idx < act_q.size()) ? act_q[idx] : 12'hfff,
               (idx >= 0 && idx < exp_q.size()) ? exp_q[idx] : 12'hfff);
    end
    tests_run++;
    if (err_count !== 32'(err0 + 1) || pkt_count !== 32'(pkt0 + 2)) begin
      tests_failed++;
      $display("FAIL short_counts: got err=%0d pkt=%0d, want %0d %0d", err_count, pkt_count, err0 + 1, pkt0 + 2);
    end
    tests_run++;
    if (locked !== 1'(m_lock)) begin
      tests_failed++;
      $display("FAIL short_locked: got %b, want %b", locked, m_lock);
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_bad_expect();
    bit to;
    int idx;
    push_packet(PKT_LEN, 0);
    push_word(8'h12, 1'b1, 1'b0);
    repeat (6) push_word(8'($urandom), 1'b1, 1'b0);
    push_word(8'h55, 1'b1, 1'b1);
    push_packet(PKT_LEN, 0);
    drain(to);
    idx = first_diff();
    tests_run++;
    if (to || idx != -1) begin
      tests_failed++;
      $display("FAIL expect_stream: idx=%0d timeout=%b act_n=%0d exp_n=%0d", idx, to, act_q.size(), exp_q.size());
    end
    tests_run++;
    if (err_count !== 32'(m_err) || pkt_count !== 32'(m_pkt) || locked !== 1'(m_lock)) begin
      tests_failed++;
      $display("FAIL expect_counts: got err=%0d pkt=%0d lock=%b, want %0d %0d %b",
               err_count, pkt_count, locked, m_err, m_pkt, m_lock);
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_random_stalls();
    bit to;
    int idx;
    stall_rand = 1; en_rand = 1; ren_bad = 0;
    repeat (3) push_packet(PKT_LEN, 1);
    push_packet(50, 1);
    push_packet(PKT_LEN, 1);
    drain(to);
    stall_rand = 0; en_rand = 0;
    idx = first_diff();
    tests_run++;
    if (to || idx != -1) begin
      tests_failed++;
      $display("FAIL stall_stream: idx=%0d timeout=%b act=%h exp=%h", idx, to,
               (idx >= 0 && idx < act_q.size()) ? act_q[idx] : 12'hfff,
               (idx >= 0 && idx < exp_q.size()) ? exp_q[idx] : 12'hfff);
    end
    tests_run++;
    if (ren_bad !== 0) begin
      tests_failed++;
      $display("FAIL stall_ren: got %0d bad r_en cycles, want 0", ren_bad);
    end
    tests_run++;
    if (err_count !== 32'(m_err) || pkt_count !== 32'(m_pkt) || locked !== 1'(m_lock)) begin
      tests_failed++;
      $display("FAIL stall_counts: got err=%0d pkt=%0d lock=%b, want %0d %0d %b",
               err_count, pkt_count, locked, m_err, m_pkt, m_lock);
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_mid_reset();
    bit to;
    int idx;
    int budget = 2000;
    push_packet(PKT_LEN, 0);
    while (act_q.size() < 50 && budget > 0) begin
      step();
      budget--;
    end
    tests_run++;
    if (budget == 0) begin tests_failed++; $display("FAIL midrst_wait: got %0d bytes, want 50", act_q.size()); end
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({ts_data, ts_valid, ts_sop, ts_eop, locked, r_en} !== 13'h0 || pkt_count !== 0 || err_count !== 0) begin
      tests_failed++;
      $display("FAIL midrst_async: got data=%h v=%b sop=%b eop=%b lock=%b ren=%b pkt=%0d err=%0d, want all 0",
               ts_data, ts_valid, ts_sop, ts_eop, locked, r_en, pkt_count, err_count);
    end
    fq.delete(); model_clear();
    @(negedge clk);
    act_q.delete(); exp_q.delete();
    rst = 1'b0;
    push_packet(PKT_LEN, 0);
    drain(to);
    idx = first_diff();
    tests_run++;
    if (to || idx != -1) begin
      tests_failed++;
      $display("FAIL midrst_stream: idx=%0d timeout=%b act_n=%0d exp_n=%0d", idx, to, act_q.size(), exp_q.size());
    end
    tests_run++;
    if (err_count !== 32'd0 || pkt_count !== 32'd1) begin
      tests_failed++;
      $display("FAIL midrst_counts: got err=%0d pkt=%0d, want 0 1", err_count, pkt_count);
    end
    act_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_garbage();
    test_short_packet();
    test_bad_expect();
    test_random_stalls();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ts_fifo_reader.md
Name: ts_fifo_reader

Overview:
- Read-side consumer of the async TS FIFO, running in the ~27 MHz output domain.
- Drains 10-bit words {data[7:0], valid, sync} from the FIFO and re-establishes packet alignment on the sync byte.
- Emits a framed byte stream with start-of-packet and end-of-packet strobes.
- Keeps saturating packet and error counters; the error counter feeds the packet-loss/QoS path used by main_control.

Parameters:
- PKT_LEN, 188, bytes per TS packet including the sync byte; 4 to 255.
- SYNC_BYTE, 8'h47, value required in the first byte of every packet.
- LOCK_PKTS, 3, consecutive good packets needed to assert locked.

Ports:
- clk  in  1  read-domain clock (~27 MHz); same clock as the FIFO rclk.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  read enable from the system; when low, no FIFO reads are issued.
- fifo_data  in  10  FIFO read data: [9:2] data, [1] valid, [0] sync.
- fifo_empty  in  1  FIFO empty flag.
- r_en  out  1  FIFO read enable.
- ts_data  out  8  output byte.
- ts_valid  out  1  ts_data is a byte belonging to a framed packet.
- ts_sop  out  1  first byte of a packet (the sync byte).
- ts_eop  out  1  byte PKT_LEN of a packet.
- locked  out  1  alignment acquired.
- pkt_count  out  32  completed packets, saturating at 32'hFFFFFFFF.
- err_count  out  32  framing errors, saturating at 32'hFFFFFFFF.

Behaviour:
- Reset (asynchronous): all outputs are 0. This includes r_en, ts_*, locked, both counters, the byte counter, the good-packet counter and rd_vld. The FSM goes to HUNT.
- Reset takes effect mid-packet as well. The partial packet is discarded, no eop is emitted, and no error is counted.
- r_en is combinational: r_en = en & ~fifo_empty & ~rst. A FIFO read never occurs while empty.
- FIFO read latency is 1 cycle. rd_vld is a register equal to r_en delayed by one cycle, and fifo_data is sampled only when rd_vld = 1.
- Word acceptance: a sampled word is "accepted" when rd_vld = 1 and valid bit = 1. Words with valid = 0 are dropped with no state change.
- Output timing: ts_* are registered, one cycle after the sampled word (2 cycles after r_en). When no word is accepted, ts_valid, ts_sop and ts_eop are 0 and ts_data holds its last value.
- A "sync word" is an accepted word with sync bit = 1 and data = SYNC_BYTE.
- FSM state HUNT:
  - ts_valid is 0.
  - On a sync word: go to PAYLOAD, byte_cnt = 1, output ts_valid = 1 and ts_sop = 1.
  - All other accepted words are discarded.
- FSM state PAYLOAD:
  - Each accepted word with sync bit = 0 increments byte_cnt and outputs ts_valid = 1.
  - When byte_cnt reaches PKT_LEN, the same output cycle asserts ts_eop = 1. pkt_count increments, good_cnt increments (saturating at LOCK_PKTS), and the FSM goes to EXPECT.
  - Short packet: an accepted word with sync bit = 1 before byte_cnt reaches PKT_LEN increments err_count and clears good_cnt and locked.
    - If that word is a sync word, a new packet starts on the same cycle (ts_sop = 1, byte_cnt = 1).
    - Otherwise the FSM goes to HUNT.
- FSM state EXPECT:
  - The next accepted word must be a sync word. If it is, start a new packet exactly as in HUNT and stay framed.
  - Any other accepted word increments err_count, clears good_cnt and locked, is not output, and sends the FSM to HUNT.
- locked: set on the cycle good_cnt reaches LOCK_PKTS; cleared on any error. Output framing does not depend on locked.
- Counters: pkt_count and err_count saturate and never wrap.
- Simultaneous events: only one word is processed per cycle. A completed packet and an error cannot coincide.
- en deasserted mid-packet: the FSM holds its state and byte_cnt. Framing resumes when en returns high.

Test Plan:
- Reset, then 3 back-to-back 188-byte packets (sync byte 0x47 with sync = 1, valid = 1) → 3 sop/eop pairs; eop lands on the 188th ts_valid byte; pkt_count = 3; locked rises with the 3rd eop; err_count = 0.
- Leading garbage (5 valid bytes 0xAA, sync = 0) before a good packet → no ts_valid during the garbage; first output byte is 0x47 with sop; err_count = 0.
- Short packet: sync word arrives after 100 bytes → err_count = 1; locked = 0; new sop on that word; a following good packet completes with pkt_count + 1.
- After an eop, next accepted byte is 0x12 with sync = 0 → err_count + 1; FSM returns to HUNT; no ts_valid until the next sync word.
- fifo_empty toggled randomly and valid = 0 bubbles inserted mid-packet → r_en never high while empty; byte order is preserved; eop still lands on the 188th byte.
- Assert rst at byte 50 of a packet → all outputs are 0 immediately (asynchronously); after release, the next packet frames correctly; err_count stays 0.
